// File: rtl/addsub_pipe_if.sv
// -----------------------------------------------------------------------------
// addsub_pipe_if
//   Operand/result bus for addsub_pipe. It carries the operand beat with its
//   valid/ready handshake and the result beat with its status flags.
//
//   Signals (WIDTH = operand/result width):
//     in_valid   master->slave  operand beat present
//     in_ready   slave->master  block can accept a beat this cycle
//     a, b       master->slave  operands A and B
//     cin        master->slave  carry-in (subtract mode: 1 = no borrow)
//     mode       master->slave  1 = add, 0 = subtract
//     out_valid  slave->master  result beat present
//     out_ready  master->slave  consumer accepts the result
//     s          slave->master  result
//     cout       slave->master  raw carry out of bit WIDTH-1
//     zero       slave->master  s == 0
//     neg        slave->master  s[WIDTH-1]
//     ovf        slave->master  signed overflow
//
//   Modports: master (operand source / result sink), slave (addsub_pipe).
// -----------------------------------------------------------------------------
interface addsub_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             zero;
    logic             neg;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, mode, out_ready,
        input  in_ready, out_valid, s, cout, zero, neg, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, mode, out_ready,
        output in_ready, out_valid, s, cout, zero, neg, ovf
    );
endinterface

// File: rtl/addsub_pipe.sv
// -----------------------------------------------------------------------------
// addsub_pipe
//   Two-stage pipelined WIDTH-bit adder/subtractor with valid/ready handshake,
//   backpressure and status flags. The carry chain is split: stage 1 adds the
//   low LO = WIDTH/2 bits, stage 2 adds the high half using the registered
//   low-half carry. Results leave directly from the stage-2 registers.
//
//   Ports:
//     clk   input  rising-edge clock
//     rst   input  synchronous, active-high reset
//     bus   addsub_pipe_if.slave  operand/result bus (see addsub_pipe_if)
//
//   Parameters:
//     WIDTH  operand/result width; even and >= 4
//
//   Optional feature (compile-time macro ADDSUB_PIPE_SAT_EN):
//     defined   - signed result saturates on overflow; direction follows the
//                 sign of operand A; ovf still reports 1; zero/neg follow the
//                 saturated result.
//     undefined - wrapped result, no saturation logic.
// -----------------------------------------------------------------------------
module addsub_pipe #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    addsub_pipe_if.slave   bus
);
    localparam int LO = WIDTH / 2;
    localparam int HI = WIDTH - LO;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic r_v1;
    logic r_v2;
    logic w_adv1;
    logic w_adv2;
    logic w_accept;

    // A stage may advance when it is empty or its successor advances, so
    // in_ready only falls when both stages hold data and the consumer stalls.
    assign w_adv2   = !r_v2 || bus.out_ready;
    assign w_adv1   = !r_v1 || w_adv2;
    assign w_accept = bus.in_valid && w_adv1;

    assign bus.in_ready = w_adv1;

    // ------------------------------------------------------------------
    // Stage 1: operand preparation and low-half add
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_bx;
    logic [LO:0]      w_lo_full;

    // Subtraction is a + ~b + cin, so cin=1 means "no borrow".
    assign w_bx      = bus.mode ? bus.b : ~bus.b;
    assign w_lo_full = {1'b0, bus.a[LO-1:0]} + {1'b0, w_bx[LO-1:0]}
                     + {{LO{1'b0}}, bus.cin};

    logic [LO-1:0] r_lo_sum;
    logic          r_c_lo;
    logic [HI-1:0] r_a_hi;
    logic [HI-1:0] r_bx_hi;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values; blocking here would let stage 2 see stage 1's new
    // contents in the same edge and collapse the pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1     <= 1'b0;
            r_lo_sum <= '0;
            r_c_lo   <= 1'b0;
            r_a_hi   <= '0;
            r_bx_hi  <= '0;
        end else if (w_adv1) begin
            r_v1 <= bus.in_valid;
            // Data registers only move on a real accept so idle cycles leave
            // them untouched.
            if (bus.in_valid) begin
                r_lo_sum <= w_lo_full[LO-1:0];
                r_c_lo   <= w_lo_full[LO];
                r_a_hi   <= bus.a[WIDTH-1:LO];
                r_bx_hi  <= w_bx[WIDTH-1:LO];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: high-half add, flags and optional saturation
    // ------------------------------------------------------------------
    logic [HI:0]      w_hi_full;
    logic [HI-1:0]    w_hi_below_msb;
    logic             w_c_msb;
    logic             w_cout;
    logic             w_ovf;
    logic [WIDTH-1:0] w_wrap;
    logic [WIDTH-1:0] w_res;

    assign w_hi_full = {1'b0, r_a_hi} + {1'b0, r_bx_hi} + {{HI{1'b0}}, r_c_lo};

    // Re-adding the high half without its MSB exposes the carry into the
    // MSB, which together with cout gives signed overflow.
    assign w_hi_below_msb = {1'b0, r_a_hi[HI-2:0]} + {1'b0, r_bx_hi[HI-2:0]}
                          + {{(HI-1){1'b0}}, r_c_lo};
    assign w_c_msb = w_hi_below_msb[HI-1];

    assign w_cout = w_hi_full[HI];
    assign w_ovf  = w_c_msb ^ w_cout;
    assign w_wrap = {w_hi_full[HI-1:0], r_lo_sum};

`ifdef ADDSUB_PIPE_SAT_EN
    // Overflow always pushes the result away from A's sign, so clamp toward
    // it: negative A -> most negative value, otherwise most positive.
    assign w_res = !w_ovf     ? w_wrap :
                   r_a_hi[HI-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                : {1'b0, {(WIDTH-1){1'b1}}};
`else
    assign w_res = w_wrap;
`endif

    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_zero;
    logic             r_neg;
    logic             r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v2   <= 1'b0;
            r_s    <= '0;
            r_cout <= 1'b0;
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_adv2) begin
            r_v2 <= r_v1;
            // An empty stage 1 only clears v2; the last result stays put.
            if (r_v1) begin
                r_s    <= w_res;
                r_cout <= w_cout;
                r_zero <= (w_res == '0);
                r_neg  <= w_res[WIDTH-1];
                r_ovf  <= w_ovf;
            end
        end
    end

    assign bus.out_valid = r_v2;
    assign bus.s         = r_s;
    assign bus.cout      = r_cout;
    assign bus.zero      = r_zero;
    assign bus.neg       = r_neg;
    assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_addsub_pipe.sv
// -----------------------------------------------------------------------------
// tb_addsub_pipe
//   Directed-vector bench for addsub_pipe at WIDTH=8. Expected values are
//   hand-computed constants; a negedge monitor records every result transfer
//   with its cycle number for the streaming and reset scenarios.
// -----------------------------------------------------------------------------
module tb_addsub_pipe;
    localparam int WIDTH = 8;

    logic clk;
    logic rst;

    addsub_pipe_if #(.WIDTH(WIDTH)) bus ();

    addsub_pipe #(.WIDTH(WIDTH)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Result transfer monitor: outputs and out_ready are stable at the
    // negedge, and a transfer happens at the following posedge.
    logic [WIDTH-1:0] q_s[$];
    int               q_cyc[$];
    int               cyc;

    initial cyc = 0;
    always @(negedge clk) begin
        cyc++;
        if (!rst && bus.out_valid && bus.out_ready) begin
            q_s.push_back(bus.s);
            q_cyc.push_back(cyc);
        end
    end

    // One beat through an otherwise empty pipe with out_ready=1.
    task automatic run_vec(input string tag, input logic m, input logic c,
                           input logic [7:0] av, input logic [7:0] bv,
                           input logic [7:0] es, input logic ec,
                           input logic ez, input logic en, input logic eo);
        bus.mode     = m;
        bus.cin      = c;
        bus.a        = av;
        bus.b        = bv;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        step();                     // edge 1: accept into stage 1
        bus.in_valid = 1'b0;
        check({tag, ".ov_early"}, 32'(bus.out_valid), 32'd0);
        step();                     // edge 2: result in stage 2
        check({tag, ".ov"},   32'(bus.out_valid), 32'd1);
        check({tag, ".s"},    32'(bus.s),         32'(es));
        check({tag, ".cout"}, 32'(bus.cout),      32'(ec));
        check({tag, ".zero"}, 32'(bus.zero),      32'(ez));
        check({tag, ".neg"},  32'(bus.neg),       32'(en));
        check({tag, ".ovf"},  32'(bus.ovf),       32'(eo));
        step();                     // drain
        check({tag, ".drained"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] held;

        n_vec         = 0;
        n_err         = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.mode      = 1'b1;

        // ---------------- reset state ----------------
        step();
        step();
        rst = 1'b0;
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst.in_ready",  32'(bus.in_ready),  32'd1);
        check("rst.s",         32'(bus.s),         32'd0);
        check("rst.flags",     {28'd0, bus.cout, bus.zero, bus.neg, bus.ovf}, 32'd0);

        // ---------------- directed vectors ----------------
        //        tag       mode cin  a      b      s      cout z  n  ovf
        run_vec("add",      1, 0, 8'h12, 8'h34, 8'h46, 0, 0, 0, 0);
        run_vec("sub_eq",   0, 1, 8'h05, 8'h05, 8'h00, 1, 1, 0, 0);
`ifdef ADDSUB_PIPE_SAT_EN
        run_vec("ovf_pos",  1, 0, 8'h7F, 8'h01, 8'h7F, 0, 0, 0, 1);
        run_vec("ovf_neg",  0, 1, 8'h80, 8'h01, 8'h80, 1, 0, 1, 1);
`else
        run_vec("ovf_pos",  1, 0, 8'h7F, 8'h01, 8'h80, 0, 0, 1, 1);
        run_vec("ovf_neg",  0, 1, 8'h80, 8'h01, 8'h7F, 1, 0, 0, 1);
`endif
        run_vec("c_lo",     1, 1, 8'h0F, 8'h00, 8'h10, 0, 0, 0, 0);
        run_vec("wrap",     1, 1, 8'hFF, 8'h00, 8'h00, 1, 1, 0, 0);
        run_vec("sub_neg",  0, 1, 8'h03, 8'h05, 8'hFE, 0, 0, 1, 0);

        // ---------------- backpressure ----------------
        // Beats k=0..3: a = 0x10+k, b = 0x01, add -> s = 0x11+k.
        q_s.delete();
        q_cyc.delete();
        bus.mode      = 1'b1;
        bus.cin       = 1'b0;
        bus.b         = 8'h01;
        bus.a         = 8'h10;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        check("bp.ready0", 32'(bus.in_ready), 32'd1);
        step();                              // beat 0 accepted
        bus.out_ready = 1'b0;
        bus.a         = 8'h11;
        check("bp.ready1", 32'(bus.in_ready), 32'd1);
        step();                              // beat 1 accepted, both full
        bus.a = 8'h12;
        check("bp.full_ready", 32'(bus.in_ready),  32'd0);
        check("bp.full_valid", 32'(bus.out_valid), 32'd1);
        held = bus.s;
        check("bp.head", 32'(held), 32'h11);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp.hold_s",     32'(bus.s),         32'(held));
            check("bp.hold_ready", 32'(bus.in_ready),  32'd0);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp.release_ready", 32'(bus.in_ready), 32'd1);
        step();                              // beat 2 accepted, beat 0 out
        bus.a = 8'h13;
        check("bp.ready_fill", 32'(bus.in_ready), 32'd1);
        step();                              // beat 3 accepted, beat 1 out
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("bp.count", 32'(q_s.size()), 32'd4);
        if (q_s.size() == 4) begin
            for (int k = 0; k < 4; k++)
                check($sformatf("bp.order%0d", k), 32'(q_s[k]), 32'(8'h11 + k));
            for (int k = 1; k < 4; k++)
                check($sformatf("bp.gap%0d", k), 32'(q_cyc[k] - q_cyc[k-1]), 32'd1);
        end

        // ---------------- reset with both stages full ----------------
        bus.out_ready = 1'b0;
        bus.mode      = 1'b1;
        bus.cin       = 1'b0;
        bus.a         = 8'h55;
        bus.b         = 8'h11;
        bus.in_valid  = 1'b1;
        step();
        bus.a = 8'h66;
        step();
        bus.in_valid = 1'b0;
        check("rf.full_valid", 32'(bus.out_valid), 32'd1);
        check("rf.full_ready", 32'(bus.in_ready),  32'd0);
        q_s.delete();
        q_cyc.delete();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rf.out_valid", 32'(bus.out_valid), 32'd0);
        check("rf.s",         32'(bus.s),         32'd0);
        check("rf.flags",     {28'd0, bus.cout, bus.zero, bus.neg, bus.ovf}, 32'd0);
        check("rf.in_ready",  32'(bus.in_ready),  32'd1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("rf.no_stale", 32'(q_s.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
